pending_encoder_32to5: RTL
==========================

PENDING_ENCODER_32TO5 -- requirements
Module: pending_encoder_32to5

Interface
REQ-001 No parameters. Widths are fixed at 32 request lines and a 5-bit index.
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 req_i  input  32  per-line set pulses; multi-hot allowed.
REQ-005 flush_i  input  1  discard all pending and held requests.
REQ-006 ready_i  input  1  consumer accepts idx_o this cycle.
REQ-007 valid_o  output  1  idx_o holds a granted index.
REQ-008 idx_o  output  5  binary index of the granted line.
REQ-009 pending_o  output  32  sticky pending register P (not yet granted).
REQ-010 count_o  output  6  population count of P, range 0..32.

Function
REQ-011 P[k] SHALL set on req_i[k]=1 and SHALL clear only when line k is loaded into the output slot, or on flush/reset.
REQ-012 The output slot (valid_o, idx_o) SHALL be free when valid_o=0 or when valid_o&ready_i=1 (handshake).
REQ-013 When the slot is free, the winner SHALL be selected from C = P | req_i.
- If C≠0: load winner index into idx_o, set valid_o=1, clear that bit in next P.
- If C=0: valid_o=0, idx_o unchanged.
REQ-014 Latency: a req_i pulse on an idle block at cycle N SHALL give valid_o=1 with the matching idx_o at cycle N+1.
REQ-015 While valid_o=1 and ready_i=0, idx_o and valid_o SHALL be held stable; new requests only accumulate in P.
REQ-016 Back-to-back: with ready_i held at 1 and k bits in C, the block SHALL emit k consecutive valid cycles with no bubble.
REQ-017 A req_i bit equal to the index being loaded in the same cycle is consumed by that load; it SHALL NOT also remain in P.
REQ-018 A req_i bit for a line already in P SHALL be absorbed; duplicates do not queue.
REQ-019 A req_i bit equal to the index currently held (not free) SHALL set P, and that line SHALL be granted again later.
REQ-020 flush_i=1 SHALL, next cycle, clear P, set valid_o=0, and drop req_i of that cycle. flush_i has priority over req_i and the handshake.
REQ-021 count_o and pending_o SHALL be registered views of P; count_o = popcount(P) always.
REQ-022 The winner computation SHALL be a single-cycle combinational priority encode of C. There SHALL be no multi-cycle search.

Reset
REQ-023 When rst_i=1 at a clock edge: P=0, valid_o=0, idx_o=0, count_o=0, priority pointer=31. rst_i overrides flush_i and req_i.
REQ-024 Reset asserted mid-handshake SHALL discard the held grant; no grant resumes after reset.

Configuration
REQ-025 Macro PENDING_ENC_ROUND_ROBIN_EN selects the priority scheme.
REQ-026 With PENDING_ENC_ROUND_ROBIN_EN defined:
- Keep a 5-bit pointer L, updated to the granted index on every load.
- Search C starting at (L+1) mod 32, ascending with wrap from 31 to 0.
- L is reset to 31, so the first search starts at 0.
REQ-027 Without PENDING_ENC_ROUND_ROBIN_EN: fixed priority, lowest set index wins. No pointer register is present.

Verification
REQ-028 Single request: idle, req_i=0x0000_0100 at N -> cycle N+1: valid_o=1, idx_o=8, pending_o=0, count_o=0.
REQ-029 Burst drain, fixed priority: req_i=0x8000_0011 one cycle, ready_i=1 -> idx_o sequence 0, 4, 31 on consecutive cycles, then valid_o=0.
REQ-030 Backpressure: same burst, ready_i=0 for 5 cycles -> idx_o=0 held, count_o=2, pending_o=0x8000_0010; after ready_i rises -> 4, 31.
REQ-031 Round robin (macro on): P holds bits 3 and 5, L=3 after granting 3, new req bit 3 -> order 5 then 3.
REQ-032 Flush: P=0xFFFF_FFFF, valid_o=1, flush_i=1 with req_i=0x1 same cycle -> next cycle P=0, count_o=0, valid_o=0.
REQ-033 Reset mid-stream: rst_i=1 during valid_o=1, ready_i=0 with count_o=7 -> next cycle all outputs 0. Then req_i=0x4 -> idx_o=2 one cycle later.

Source files
------------

// File: rtl/pending_encoder_32to5.sv
// Sticky 32-line request collector feeding a one-entry grant slot.
// Ports: clk_i, rst_i (sync high), req_i[31:0], flush_i, ready_i,
//   valid_o, idx_o[4:0], pending_o[31:0], count_o[5:0].
// PENDING_ENC_ROUND_ROBIN_EN: round-robin search from last grant + 1;
//   undefined: fixed priority, lowest index wins.
module pending_encoder_32to5 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] req_i,
  input  logic        flush_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [4:0]  idx_o,
  output logic [31:0] pending_o,
  output logic [5:0]  count_o
);

  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic [31:0] cand;
  logic        valid_q;
  logic        valid_d;
  logic [4:0]  idx_q;
  logic [4:0]  idx_d;
  logic [5:0]  count_q;
  logic        slot_free;
  logic        win_hit;
  logic [4:0]  win_idx;

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  assign slot_free = !valid_q || ready_i;
  assign cand      = pend_q | req_i;

`ifdef PENDING_ENC_ROUND_ROBIN_EN
  logic [4:0] ptr_q;
  logic [4:0] ptr_d;

  // Walk from ptr+1 upward; 5-bit arithmetic gives the 31->0 wrap.
  always_comb begin
    logic [4:0] k;
    win_hit = 1'b0;
    win_idx = '0;
    k       = '0;
    for (int i = 0; i < 32; i++) begin
      k = ptr_q + 5'd1 + 5'(i);
      if (!win_hit && cand[k]) begin
        win_hit = 1'b1;
        win_idx = k;
      end
    end
  end
`else
  // Descending scan so the lowest set index is the last write.
  always_comb begin
    win_hit = |cand;
    win_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = 5'(i);
      end
    end
  end
`endif

  always_comb begin
    pend_d  = cand;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (flush_i) begin
      pend_d  = '0;
      valid_d = 1'b0;
    end else if (slot_free) begin
      valid_d = win_hit;
      if (win_hit) begin
        idx_d           = win_idx;
        // Loading a line consumes it, even if it also pulsed now.
        pend_d[win_idx] = 1'b0;
      end
    end
  end

`ifdef PENDING_ENC_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (!flush_i && slot_free && win_hit) begin
      ptr_d = win_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 5'd31;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      count_q <= popcnt(pend_d);
    end
  end

  assign valid_o   = valid_q;
  assign idx_o     = idx_q;
  assign pending_o = pend_q;
  assign count_o   = count_q;

endmodule
